// File: rtl/entrada_tempo.sv
// Keypad front end for the microwave min / dez_seg / seg down-counter chain:
// collects BCD digits, loads the counters and sequences start / pause / cancel.
module entrada_tempo #(
    parameter int unsigned DSEG_MAX  = 5,
    parameter int unsigned DIGIT_MAX = 9
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop,
    input  logic       clear_entry,
    input  logic       time_zero,
    output logic [3:0] data_min,
    output logic [3:0] data_dseg,
    output logic [3:0] data_seg,
    output logic       load,
    output logic       en,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_LOAD,
        ST_RUN,
        ST_PAUSE,
        ST_FINISH
    } state_t;

    localparam logic [3:0] DSEG_MAX_C  = DSEG_MAX[3:0];
    localparam logic [3:0] DIGIT_MAX_C = DIGIT_MAX[3:0];

    state_t     state_q, state_d;
    logic [3:0] min_q, min_d;
    logic [3:0] dseg_q, dseg_d;
    logic [3:0] seg_q, seg_d;
    logic       any_digit;

    assign any_digit = (min_q != 4'd0) || (dseg_q != 4'd0) || (seg_q != 4'd0);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        dseg_d  = dseg_q;
        seg_d   = seg_q;

        unique case (state_q)
            ST_ENTRY: begin
                if (clear_entry) begin
                    min_d  = 4'd0;
                    dseg_d = 4'd0;
                    seg_d  = 4'd0;
                end else if (start) begin
                    if (any_digit) begin
                        if (dseg_q > DSEG_MAX_C) dseg_d = DSEG_MAX_C;
                        state_d = ST_LOAD;
                    end
                end else if (key_valid && (key_code <= DIGIT_MAX_C)) begin
                    min_d  = dseg_q;
                    dseg_d = seg_q;
                    seg_d  = key_code;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                // Reaching 0:00 outranks a pause request in the same cycle.
                if (time_zero)  state_d = ST_FINISH;
                else if (stop)  state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (stop) begin
                    min_d   = 4'd0;
                    dseg_d  = 4'd0;
                    seg_d   = 4'd0;
                    state_d = ST_ENTRY;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_FINISH: begin
                min_d   = 4'd0;
                dseg_d  = 4'd0;
                seg_d   = 4'd0;
                state_d = ST_ENTRY;
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!clearn) begin
            state_q <= ST_ENTRY;
            min_q   <= 4'd0;
            dseg_q  <= 4'd0;
            seg_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            dseg_q  <= dseg_d;
            seg_q   <= seg_d;
        end
    end

    assign data_min  = min_q;
    assign data_dseg = dseg_q;
    assign data_seg  = seg_q;
    assign load      = (state_q != ST_LOAD);
    // Gated by time_zero combinationally so the chain never wraps past 0:00.
    assign en        = (state_q == ST_RUN) && !time_zero;
    assign busy      = (state_q != ST_ENTRY);
    assign done      = (state_q == ST_FINISH);

endmodule

// File: doc/entrada_tempo.md
Name: entrada_tempo

Overview:
- Front end that writes into the min / dez_seg / seg down-counter chain of the microwave timer.
- Collects keypad digits into three BCD registers, presents them on the counters' data inputs and issues the active-low load strobe.
- Drives the chain's count enable and stops it when the chain reports all-zero; handles start / pause / cancel.

Parameters:
- DSEG_MAX, 5, highest legal tens-of-seconds digit; larger entries are clamped to this value at start.
- DIGIT_MAX, 9, highest accepted key code; codes above it are ignored.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- clearn  in  1  reset; one clock, reset is synchronous and active-low.
- key_valid  in  1  one-cycle pulse: key_code holds a pressed key.
- key_code  in  4  key value, 0..15.
- start  in  1  one-cycle pulse: start / resume.
- stop  in  1  one-cycle pulse: pause / cancel.
- clear_entry  in  1  one-cycle pulse: zero the entered digits.
- time_zero  in  1  AND of count_end from the three counters (chain reads 0:00).
- data_min  out  4  minutes digit to the counter data input.
- data_dseg  out  4  tens-of-seconds digit.
- data_seg  out  4  seconds digit.
- load  out  1  active-low load strobe to the counters.
- en  out  1  count enable to the counters.
- busy  out  1  high whenever state is not ENTRY.
- done  out  1  one-cycle pulse when the countdown reaches 0:00.

Behaviour:
- States: ENTRY, LOAD, RUN, PAUSE, FINISH. State and digit registers update only on posedge clk.
- Reset: clearn low at a posedge, in any state (including mid-RUN or PAUSE), gives:
  - state ENTRY;
  - data_min = data_dseg = data_seg = 0;
  - load = 1, en = 0, busy = 0, done = 0.
- Reset has priority over every other input.
- Outputs are decoded from state; en also uses time_zero (see RUN).
  - load = 0 only in LOAD.
  - busy = 1 in LOAD, RUN, PAUSE, FINISH.
  - done = 1 only in FINISH.
- ENTRY: load = 1, en = 0. Input priority in one cycle: clear_entry > start > key_valid.
  - clear_entry: all three digits <= 0.
  - start with all three digits zero: ignored, stay in ENTRY.
  - start with any digit nonzero:
    - if data_dseg > DSEG_MAX, data_dseg <= DSEG_MAX;
    - next state LOAD.
  - key_valid with key_code <= DIGIT_MAX: shift left.
    - data_min <= data_dseg, data_dseg <= data_seg, data_seg <= key_code.
    - The oldest digit falls off the top.
  - key_valid with key_code > DIGIT_MAX: no change.
  - stop: no effect.
- LOAD: exactly one cycle.
  - load = 0, en = 0; the counters capture data_* on this posedge.
  - Inputs ignored. Next state RUN.
- RUN:
  - en = ~time_zero, combinational, so the chain never wraps 0 -> 5/9.
  - time_zero = 1: next state FINISH (takes priority over stop).
  - Else stop = 1: next state PAUSE.
  - key_valid, clear_entry and start are ignored.
- PAUSE: en = 0, load = 1; the counters hold their value.
  - start: next state RUN. Counting resumes with no reload.
  - stop: clear all digits, next state ENTRY (cancel).
  - start and stop in the same cycle: stop wins.
- FINISH: exactly one cycle.
  - done = 1, en = 0.
  - Digits <= 0, next state ENTRY.
- Latency:
  - start in ENTRY to load low: 1 cycle.
  - First en high: 2 cycles after start.
  - time_zero rising in RUN to done: 1 cycle.
- The digit registers are the only data storage. The block never reads back counter values.

Test Plan:
- Reset mid-RUN:
  - Stimulus: enter 1,3,0, start, run 5 cycles, drive clearn low for one posedge.
  - Required: next cycle state ENTRY; data_* = 0; load = 1; en = 0; busy = 0.
- Digit shift:
  - Stimulus: keys 2,4,5,7.
  - Required: data_min = 4, data_dseg = 5, data_seg = 7. A following key code 12 leaves all three unchanged.
- Clamp and load:
  - Stimulus: keys 1,8,3, then start.
  - Required: next cycle data_dseg = 5 and load = 0 for exactly one cycle; cycle after that en = 1 with load = 1.
- Zero start ignored:
  - Stimulus: after reset, pulse start.
  - Required: state stays ENTRY, load stays 1, busy stays 0.
- Pause / resume / cancel:
  - Stimulus: in RUN, stop.
  - Required: en = 0 next cycle.
  - Stimulus: start.
  - Required: en = 1 again with no load pulse.
  - Stimulus: stop in RUN, then stop again in PAUSE.
  - Required: ENTRY, digits 0.
  - Stimulus: start and stop together in PAUSE.
  - Required: stop wins, returns to ENTRY.
- Finish:
  - Stimulus: in RUN, raise time_zero in the same cycle as stop.
  - Required: en = 0 combinationally in that cycle; next cycle done = 1 for exactly one cycle; then ENTRY with digits 0 and busy = 0.
